bm_inference_scheduler: RTL and testbench

Autonomous sequencer for the stochastic Bayesian memristor array, used alongside chip_control's single-shot register path.
- Runs a programmed number of stochastic inference iterations over four observations.
- Per iteration: drives the precharge/pulse/off sequence for each observation, then samples the 4-class bit_out.
- Accumulates per-class counts and reports the argmax class.
- Sits between the AXI-Lite control block (start, observations, counts) and the array control pins.

---
 rtl/bm_pkg.sv | 42 ++++
 rtl/bm_inference_scheduler_counter.sv | 42 ++++
 rtl/bm_inference_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_bm_inference_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// bm_pkg: states, control bundle and constants shared by the
// Bayesian memristor inference scheduler.
package bm_pkg;

  localparam int BM_NUM_CLASSES = 4;
  localparam int BM_OBS_W = 9;

  typedef enum logic [3:0] {
    IDLE,
    SEED,
    RESEED,
    SETUP,
    PRECHARGE,
    PULSE,
    OFF,
    SAMPLE,
    DONE
  } bm_state_t;

  typedef struct packed {
    logic       cbl;
    logic       cblen;
    logic       csl;
    logic       cwl;
    logic       inference;
    logic       load_seed;
    logic       read_1;
    logic       read_8;
    logic       load_mem;
    logic       read_out;
    logic       stoch_log;
    logic [7:0] col;
    logic [7:0] row;
    logic [7:0] seeds;
  } bm_ctrl_t;

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/bm_inference_scheduler_counter.sv
// bm_class_counter: per-class saturating vote counters with a
// registered argmax (ties resolve to the lowest class index).
import bm_pkg::*;

module bm_class_counter #(
  parameter int COUNT_W = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic                                      inc_en,
  input  logic [BM_NUM_CLASSES-1:0]                 bits,
  input  logic                                      latch,
  output logic [BM_NUM_CLASSES-1:0][COUNT_W-1:0]    counts,
  output logic [1:0]                                argmax
);

  logic [1:0] best;

  always_comb begin
    best = '0;
    for (int c = 1; c < BM_NUM_CLASSES; c++)
      if (counts[c] > counts[best]) best = 2'(c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counts <= '0;
      argmax <= '0;
    end else begin
      if (clear) begin
        counts <= '0;
      end else if (inc_en) begin
        for (int c = 0; c < BM_NUM_CLASSES; c++)
          if (counts[c] != '1)
            counts[c] <= counts[c] + COUNT_W'(bits[c]);
      end
      if (latch) argmax <= best;
    end
  end

endmodule

// File: rtl/bm_inference_scheduler.sv
// bm_inference_scheduler: iterated stochastic inference sequencer.
// Define BM_LFSR_SEED_EN to reseed from an internal LFSR each iteration.
import bm_pkg::*;

module bm_inference_scheduler #(
  parameter int PULSE_CYCLES = 2,
  parameter int COUNT_W = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [COUNT_W-1:0]                       iterations,
  input  logic [BM_NUM_CLASSES-1:0][BM_OBS_W-1:0]  obs,
  input  logic [7:0]                               seed,
  output logic                                     busy,
  output logic                                     done,
  output logic [BM_NUM_CLASSES-1:0][COUNT_W-1:0]   counts,
  output logic [1:0]                               argmax,
  output logic                                     CBL,
  output logic                                     CBLEN,
  output logic                                     CSL,
  output logic                                     CWL,
  output logic                                     inference,
  output logic                                     load_seed,
  output logic                                     read_1,
  output logic                                     read_8,
  output logic                                     load_mem,
  output logic                                     read_out,
  output logic                                     stoch_log,
  output logic [7:0]                               adr_full_col,
  output logic [7:0]                               adr_full_row,
  output logic [7:0]                               seeds,
  input  logic [BM_NUM_CLASSES-1:0]                bit_out
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);

  bm_state_t state, nxt;
  logic [1:0]         k;
  logic [PW-1:0]      pcnt;
  logic [COUNT_W-1:0] it;
  logic [COUNT_W-1:0] iter_reg;
  logic [7:0]         seed_reg;
  logic [BM_NUM_CLASSES-1:0][BM_OBS_W-1:0] obs_reg;
  logic               go;
  logic               last_it;
  bm_ctrl_t           ctrl;

  assign go = (state == IDLE) && start && !abort;
  // it+1 never wraps: it stays below iter_reg
  assign last_it = (it + 1'b1) == iter_reg;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (start) nxt = SEED;
      SEED:      nxt = (iter_reg == '0) ? DONE : SETUP;
      RESEED:    nxt = SETUP;
      SETUP:     nxt = PRECHARGE;
      PRECHARGE: nxt = PULSE;
      PULSE:     if (pcnt == P_LAST) nxt = OFF;
      OFF:       nxt = (k == 2'd3) ? SAMPLE : SETUP;
      SAMPLE: begin
        if (last_it) nxt = DONE;
`ifdef BM_LFSR_SEED_EN
        else nxt = RESEED;
`else
        else nxt = SETUP;
`endif
      end
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      pcnt     <= '0;
      it       <= '0;
      iter_reg <= '0;
      seed_reg <= '0;
      obs_reg  <= '0;
    end else begin
      state <= nxt;
      pcnt  <= (state == PULSE && nxt == PULSE) ? pcnt + 1'b1 : '0;
      if (go) begin
        obs_reg  <= obs;
        seed_reg <= seed;
        iter_reg <= iterations;
        k        <= '0;
        it       <= '0;
      end
      if (state == OFF && k != 2'd3) k <= k + 1'b1;
      if (state == SAMPLE) begin
        k  <= '0;
        it <= it + 1'b1;
      end
    end
  end

`ifdef BM_LFSR_SEED_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'h01;
    else if (go) lfsr <= (seed == 8'h00) ? 8'h01 : seed;
    else if (state == RESEED) lfsr <= lfsr_next(lfsr);
  end
`endif

  always_comb begin
    ctrl = '0;
    if (state inside {SETUP, PRECHARGE, PULSE, OFF}) begin
      ctrl.col = {k, 3'b000, obs_reg[k][2:0]};
      ctrl.row = {2'b00, obs_reg[k][8:3]};
    end
    unique case (state)
      SEED: begin
        ctrl.load_seed = 1'b1;
        ctrl.seeds     = seed_reg;
      end
      RESEED: begin
        ctrl.load_seed = 1'b1;
`ifdef BM_LFSR_SEED_EN
        ctrl.seeds     = lfsr;
`endif
      end
      PRECHARGE: begin
        ctrl.csl       = 1'b1;
        ctrl.cwl       = 1'b1;
        ctrl.read_8    = 1'b1;
        ctrl.stoch_log = 1'b1;
      end
      PULSE: begin
        ctrl.cwl       = 1'b1;
        ctrl.read_8    = 1'b1;
        ctrl.stoch_log = 1'b1;
      end
      OFF: begin
        ctrl.inference = 1'b1;
        ctrl.read_8    = 1'b1;
        ctrl.stoch_log = 1'b1;
      end
      SAMPLE: begin
        ctrl.read_out  = 1'b1;
        ctrl.inference = 1'b1;
        ctrl.stoch_log = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign CBL          = ctrl.cbl;
  assign CBLEN        = ctrl.cblen;
  assign CSL          = ctrl.csl;
  assign CWL          = ctrl.cwl;
  assign inference    = ctrl.inference;
  assign load_seed    = ctrl.load_seed;
  assign read_1       = ctrl.read_1;
  assign read_8       = ctrl.read_8;
  assign load_mem     = ctrl.load_mem;
  assign read_out     = ctrl.read_out;
  assign stoch_log    = ctrl.stoch_log;
  assign adr_full_col = ctrl.col;
  assign adr_full_row = ctrl.row;
  assign seeds        = ctrl.seeds;

  bm_class_counter #(
    .COUNT_W (COUNT_W)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (go),
    .inc_en ((state == SAMPLE) && !abort),
    .bits   (bit_out),
    .latch  (state == DONE),
    .counts (counts),
    .argmax (argmax)
  );

endmodule

// File: tb/tb_bm_inference_scheduler.sv
// tb_bm_inference_scheduler: cycle schedule model plus directed
// runs for the inference scheduler (default and 4-bit counters).
`timescale 1ns/1ps

module tb_bm_inference_scheduler;
  import bm_pkg::*;

  localparam int PC = 2;
`ifdef BM_LFSR_SEED_EN
  localparam int DONE_A = 111;
  localparam int DONE_B = 67;
  localparam int DONE_F = 331;
`else
  localparam int DONE_A = 107;
  localparam int DONE_B = 65;
  localparam int DONE_F = 317;
`endif

  // {CBL,CBLEN,CSL,CWL,inference,load_seed,read_1,read_8,load_mem,read_out,stoch_log}
  localparam logic [10:0] K_SEED = 11'b00000100000;
  localparam logic [10:0] K_PRE  = 11'b00110001001;
  localparam logic [10:0] K_PUL  = 11'b00010001001;
  localparam logic [10:0] K_OFF  = 11'b00001001001;
  localparam logic [10:0] K_SMP  = 11'b00001000011;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [10:0] ctl;
    logic [7:0]  col;
    logic [7:0]  row;
    logic [7:0]  seeds;
  } exp_t;

  logic clk, rst_n, start, abort, start4, abort4;
  logic [15:0] iterations;
  logic [3:0] iterations4;
  logic [3:0][8:0] obs;
  logic [7:0] seed;
  logic [3:0] bit_out;
  logic busy, done, busy4, done4;
  logic [3:0][15:0] counts;
  logic [3:0][3:0] counts4;
  logic [1:0] argmax, argmax4;
  logic CBL, CBLEN, CSL, CWL, inference, load_seed;
  logic read_1, read_8, load_mem, read_out, stoch_log;
  logic [7:0] adr_full_col, adr_full_row, seeds;
  wire [10:0] x4;
  wire [7:0] col4, row4, seeds4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int cwl_pulse_tot = 0;
  int ls_tot = 0;
  int done_tot = 0;
  int done_at = 0;
  int done4_at = 0;

  exp_t exp_q[$];
  logic [3:0][15:0] cnt_q[$];
  logic [3:0][15:0] idle_cnt = '0;

  bm_inference_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .iterations(iterations), .obs(obs), .seed(seed),
    .busy(busy), .done(done), .counts(counts), .argmax(argmax),
    .CBL(CBL), .CBLEN(CBLEN), .CSL(CSL), .CWL(CWL),
    .inference(inference), .load_seed(load_seed), .read_1(read_1),
    .read_8(read_8), .load_mem(load_mem), .read_out(read_out),
    .stoch_log(stoch_log), .adr_full_col(adr_full_col),
    .adr_full_row(adr_full_row), .seeds(seeds), .bit_out(bit_out)
  );

  bm_inference_scheduler #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .iterations(iterations4), .obs(obs), .seed(seed),
    .busy(busy4), .done(done4), .counts(counts4), .argmax(argmax4),
    .CBL(x4[10]), .CBLEN(x4[9]), .CSL(x4[8]), .CWL(x4[7]),
    .inference(x4[6]), .load_seed(x4[5]), .read_1(x4[4]),
    .read_8(x4[3]), .load_mem(x4[2]), .read_out(x4[1]),
    .stoch_log(x4[0]), .adr_full_col(col4),
    .adr_full_row(row4), .seeds(seeds4), .bit_out(bit_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic push(input logic d, input logic [10:0] ctl,
                      input logic [7:0] col, input logic [7:0] row,
                      input logic [7:0] sd, input logic [3:0][15:0] c);
    exp_t e;
    e.busy = 1'b1;
    e.done = d;
    e.ctl = ctl;
    e.col = col;
    e.row = row;
    e.seeds = sd;
    exp_q.push_back(e);
    cnt_q.push_back(c);
  endtask

  // Expected outputs for cycles 1.. of a run started at cycle 0
  task automatic plan_run(input int n, input logic [3:0][8:0] o,
                          input logic [7:0] sd, input logic [3:0] b);
    logic [3:0][15:0] c;
    logic [7:0] l, col, row;
    logic [1:0] jj;
    c = '0;
    l = (sd == 8'h00) ? 8'h01 : sd;
    push(1'b0, K_SEED, 8'h00, 8'h00, sd, c);
    for (int i = 0; i < n; i++) begin
`ifdef BM_LFSR_SEED_EN
      if (i > 0) begin
        push(1'b0, K_SEED, 8'h00, 8'h00, l, c);
        l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
`endif
      for (int j = 0; j < 4; j++) begin
        jj = 2'(j);
        col = {jj, 3'b000, o[j][2:0]};
        row = {2'b00, o[j][8:3]};
        push(1'b0, 11'b0, col, row, 8'h00, c);
        push(1'b0, K_PRE, col, row, 8'h00, c);
        for (int p = 0; p < PC; p++) push(1'b0, K_PUL, col, row, 8'h00, c);
        push(1'b0, K_OFF, col, row, 8'h00, c);
      end
      push(1'b0, K_SMP, 8'h00, 8'h00, 8'h00, c);
      for (int cc = 0; cc < 4; cc++)
        if (b[cc] && c[cc] != 16'hFFFF) c[cc] = c[cc] + 16'd1;
    end
    push(1'b1, 11'b0, 8'h00, 8'h00, 8'h00, c);
    idle_cnt = c;
  endtask

  initial begin : cmp
    exp_t e, a;
    logic [3:0][15:0] ec;
    forever begin
      @(negedge clk);
      a = {busy, done, CBL, CBLEN, CSL, CWL, inference, load_seed,
           read_1, read_8, load_mem, read_out, stoch_log,
           adr_full_col, adr_full_row, seeds};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ec = cnt_q.pop_front();
      end else begin
        e = '0;
        ec = idle_cnt;
      end
      chk($sformatf("pins@%0d", cyc - t0), 64'(a), 64'(e));
      chk($sformatf("counts@%0d", cyc - t0), counts, ec);
      if (CWL && !CSL) cwl_pulse_tot++;
      if (load_seed) ls_tot++;
      if (done) begin
        done_tot++;
        done_at = cyc - t0;
      end
      if (done4) done4_at = cyc - t0;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < t0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch();
    @(posedge clk);
    #1;
    start = 1'b1;
    t0 = cyc;
    wait_cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 64'(n < budget), 64'd1);
  endtask

  initial begin : stim
    int s_cwl, s_ls, s_done, n;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start4 = 1'b0;
    abort4 = 1'b0;
    iterations = '0;
    iterations4 = '0;
    obs = '0;
    seed = '0;
    bit_out = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_counts", counts, 64'd0);
    chk("rst_argmax", 64'(argmax), 64'd0);
    chk("rst_ctl", 64'({CSL, CWL, load_seed, read_out, inference}), 64'd0);

    // A: single class votes every iteration
    obs[0] = 9'h007;
    obs[1] = 9'h1AB;
    obs[2] = 9'h0C5;
    obs[3] = 9'h138;
    seed = 8'h5A;
    iterations = 16'd5;
    bit_out = 4'b0100;
    s_cwl = cwl_pulse_tot;
    launch();
    plan_run(5, obs, seed, bit_out);
    wait_cyc(2);
    @(negedge clk);
    chk("A_col0", 64'(adr_full_col), 64'h07);
    wait_cyc(7);
    @(negedge clk);
    chk("A_col1", 64'(adr_full_col), 64'h43);
    chk("A_row1", 64'(adr_full_row), 64'h35);
    wait_idle(200, "A");
    chk("A_done_cyc", 64'(done_at), 64'(DONE_A));
    chk("A_cnt2", 64'(counts[2]), 64'd5);
    chk("A_cnt0", 64'(counts[0]), 64'd0);
    chk("A_argmax", 64'(argmax), 64'd2);
    chk("A_pulse_cwl", 64'(cwl_pulse_tot - s_cwl), 64'd40);

    // B: start while busy must be ignored
    iterations = 16'd3;
    bit_out = 4'b1010;
    launch();
    plan_run(3, obs, seed, bit_out);
    wait_cyc(10);
    start = 1'b1;
    iterations = 16'd9;
    obs[0] = 9'h1FF;
    wait_cyc(11);
    start = 1'b0;
    iterations = 16'd3;
    obs[0] = 9'h007;
    wait_idle(150, "B");
    chk("B_done_cyc", 64'(done_at), 64'(DONE_B));
    chk("B_counts", counts, {16'd3, 16'd0, 16'd3, 16'd0});
    chk("B_argmax_tie", 64'(argmax), 64'd1);

    // C: zero iterations
    iterations = 16'd0;
    s_ls = ls_tot;
    launch();
    plan_run(0, obs, seed, bit_out);
    wait_idle(20, "C");
    chk("C_done_cyc", 64'(done_at), 64'd2);
    chk("C_load_seed", 64'(ls_tot - s_ls), 64'd1);
    chk("C_counts", counts, 64'd0);
    chk("C_argmax", 64'(argmax), 64'd0);

    // D: abort during the second iteration
    iterations = 16'd5;
    bit_out = 4'b0011;
    s_done = done_tot;
    launch();
    plan_run(5, obs, seed, bit_out);
    wait_cyc(30);
    abort = 1'b1;
    wait_cyc(31);
    abort = 1'b0;
    exp_q.delete();
    cnt_q.delete();
    idle_cnt = {16'd0, 16'd0, 16'd1, 16'd1};
    @(negedge clk);
    chk("D_busy", 64'(busy), 64'd0);
    chk("D_cnt0", 64'(counts[0]), 64'd1);
    chk("D_cnt2", 64'(counts[2]), 64'd0);
    repeat (5) @(negedge clk);
    chk("D_no_done", 64'(done_tot - s_done), 64'd0);

    // E: start and abort together in IDLE
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("E_busy", 64'(busy), 64'd0);
    chk("E_cnt0", 64'(counts[0]), 64'd1);

    // F: 4-bit counters at full range, run twice
    bit_out = 4'b1111;
    iterations4 = 4'd15;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      start4 = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      @(negedge clk);
      chk($sformatf("F%0d_clear", r), 64'(counts4), 64'd0);
      n = 0;
      while (busy4 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("F%0d_timeout", r), 64'(n < 500), 64'd1);
      chk($sformatf("F%0d_done_cyc", r), 64'(done4_at), 64'(DONE_F));
      chk($sformatf("F%0d_counts", r), 64'(counts4), 64'hFFFF);
      chk($sformatf("F%0d_argmax", r), 64'(argmax4), 64'd0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
